// File: rtl/logic_op_sweeper.sv
// logic_op_sweeper: drives all 32 {sel,a,b} vectors into an external 8-function
// logic unit, holds each vector SETTLE cycles, and captures op_out into a
// 32-bit truth table (bit index = {sel,a,b}).
// Optional golden-map self-check is built when LOGIC_SWEEP_SELF_CHECK_EN is defined.
module logic_op_sweeper #(
    parameter int SETTLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        op_out,
    output logic        op_a,
    output logic        op_b,
    output logic [2:0]  op_sel,
    output logic        busy,
    output logic        done,
    output logic [31:0] table_q,
    output logic        pass,
    output logic [5:0]  err_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_DONE} state_t;

    localparam logic [3:0] C_LAST = 4'(SETTLE - 1);

    state_t      r_state;
    logic [4:0]  r_idx;
    logic [3:0]  r_cnt;
    logic [4:0]  r_vec;
    logic        r_busy;
    logic        r_done;
    logic [31:0] r_table;

    logic        w_last;
    logic [4:0]  w_idx_next;

    assign w_last     = (r_cnt == C_LAST);
    assign w_idx_next = r_idx + 5'd1;

    assign op_sel  = r_vec[4:2];
    assign op_a    = r_vec[1];
    assign op_b    = r_vec[0];
    assign busy    = r_busy;
    assign done    = r_done;
    assign table_q = r_table;

    // Sweep sequencer: vector index, settle counter, driven vector, capture table.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_idx   <= 5'd0;
            r_cnt   <= 4'd0;
            r_vec   <= 5'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_table <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_DRIVE;
                        r_idx   <= 5'd0;
                        r_cnt   <= 4'd0;
                        r_vec   <= 5'd0;
                        r_table <= 32'd0;
                        r_busy  <= 1'b1;
                    end
                end
                S_DRIVE: begin
                    if (!w_last) begin
                        r_cnt <= r_cnt + 4'd1;
                    end else begin
                        r_table[r_idx] <= op_out;
                        r_cnt          <= 4'd0;
                        if (r_idx == 5'd31) begin
                            // Last vector stays on the unit's inputs after the sweep.
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_idx <= w_idx_next;
                            r_vec <= w_idx_next;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

`ifdef LOGIC_SWEEP_SELF_CHECK_EN
    localparam logic [31:0] GOLDEN = 32'h7796E813;

    logic       r_pass;
    logic [5:0] r_err;
    logic       w_mis;
    logic [5:0] w_err_next;

    assign w_mis      = op_out ^ GOLDEN[r_idx];
    assign w_err_next = r_err + {5'd0, w_mis};
    assign pass       = r_pass;
    assign err_cnt    = r_err;

    // Golden compare per capture; pass includes the final capture's result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pass <= 1'b0;
            r_err  <= 6'd0;
        end else if (r_state == S_IDLE && start) begin
            r_pass <= 1'b0;
            r_err  <= 6'd0;
        end else if (r_state == S_DRIVE && w_last) begin
            r_err <= w_err_next;
            if (r_idx == 5'd31) begin
                r_pass <= (w_err_next == 6'd0);
            end
        end
    end
`else
    assign pass    = 1'b0;
    assign err_cnt = 6'd0;
`endif

endmodule

// File: tb/tb_logic_op_sweeper.sv
// tb_logic_op_sweeper: two sweepers (SETTLE=1 and SETTLE=3), each wrapped around
// a behavioural logic unit whose output can be corrupted per vector by a mask.
module tb_logic_op_sweeper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start_v  [2];
    logic        op_out_v [2];
    logic        op_a_v   [2];
    logic        op_b_v   [2];
    logic [2:0]  op_sel_v [2];
    logic        busy_v   [2];
    logic        done_v   [2];
    logic [31:0] tbl_v    [2];
    logic        pass_v   [2];
    logic [5:0]  err_v    [2];
    logic [31:0] mask_v   [2];

    int total  = 0;
    int passed = 0;
    int fails  = 0;

    // Function unit behaviour, written from the function names.
    function automatic logic ref_fn(input logic [2:0] s, input logic a, input logic b);
        case (s)
            3'd0:    return !a;
            3'd1:    return !(a | b);
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return !(a ^ b);
            default: return !(a & b);
        endcase
    endfunction

    function automatic logic [31:0] golden_word();
        logic [31:0] w;
        logic [4:0]  v;
        w = 32'd0;
        for (int i = 0; i < 32; i++) begin
            v    = 5'(i);
            w[i] = ref_fn(v[4:2], v[1], v[0]);
        end
        return w;
    endfunction

    function automatic int popcount(input logic [31:0] m);
        int n;
        n = 0;
        for (int i = 0; i < 32; i++) n += int'(m[i]);
        return n;
    endfunction

    assign op_out_v[0] = ref_fn(op_sel_v[0], op_a_v[0], op_b_v[0]) ^ mask_v[0][{op_sel_v[0], op_a_v[0], op_b_v[0]}];
    assign op_out_v[1] = ref_fn(op_sel_v[1], op_a_v[1], op_b_v[1]) ^ mask_v[1][{op_sel_v[1], op_a_v[1], op_b_v[1]}];

    logic_op_sweeper #(.SETTLE(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .op_out(op_out_v[0]),
        .op_a(op_a_v[0]), .op_b(op_b_v[0]), .op_sel(op_sel_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .table_q(tbl_v[0]),
        .pass(pass_v[0]), .err_cnt(err_v[0])
    );

    logic_op_sweeper #(.SETTLE(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .op_out(op_out_v[1]),
        .op_a(op_a_v[1]), .op_b(op_b_v[1]), .op_sel(op_sel_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .table_q(tbl_v[1]),
        .pass(pass_v[1]), .err_cnt(err_v[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] vec(input int u);
        return {27'd0, op_sel_v[u], op_a_v[u], op_b_v[u]};
    endfunction

    task automatic check_selfchk(input string tag, input int u, input logic [31:0] mask);
`ifdef LOGIC_SWEEP_SELF_CHECK_EN
        check({tag, "_err"},  {26'd0, err_v[u]}, 32'(popcount(mask)));
        check({tag, "_pass"}, {31'd0, pass_v[u]}, {31'd0, (mask == 32'd0)});
`else
        check({tag, "_err"},  {26'd0, err_v[u]}, 32'd0);
        check({tag, "_pass"}, {31'd0, pass_v[u]}, 32'd0);
`endif
    endtask

    // mode 0: plain sweep; 1: start pulses at edges 5 and 20; 2: start held high
    task automatic run_sweep(input string tag, input int u, input int s,
                             input logic [31:0] mask, input int mode);
        logic [31:0] exp_t;
        int          n;
        int          seen;
        n         = 32 * s;
        exp_t     = golden_word() ^ mask;
        mask_v[u] = mask;
        start_v[u] = 1'b1;
        @(posedge clk); #1;
        check({tag, "_busy0"}, {31'd0, busy_v[u]}, 32'd1);
        check({tag, "_vec0"}, vec(u), 32'd0);
        check({tag, "_tclr"}, tbl_v[u], 32'd0);
        check({tag, "_eclr"}, {26'd0, err_v[u]}, 32'd0);
        for (int e = 1; e < n; e++) begin
            start_v[u] = (mode == 2) || (mode == 1 && (e == 5 || e == 20));
            @(posedge clk); #1;
            check({tag, "_busy"}, {31'd0, busy_v[u]}, 32'd1);
            check({tag, "_vec"}, vec(u), 32'(e / s));
            check({tag, "_nodone"}, {31'd0, done_v[u]}, 32'd0);
        end
        start_v[u] = (mode == 2);
        @(posedge clk); #1;
        check({tag, "_done"}, {31'd0, done_v[u]}, 32'd1);
        check({tag, "_busyoff"}, {31'd0, busy_v[u]}, 32'd0);
        check({tag, "_table"}, tbl_v[u], exp_t);
        check_selfchk(tag, u, mask);
        @(posedge clk); #1;
        check({tag, "_donelow"}, {31'd0, done_v[u]}, 32'd0);
        check({tag, "_idle"}, {31'd0, busy_v[u]}, 32'd0);
        check({tag, "_lastvec"}, vec(u), 32'd31);
        check({tag, "_hold"}, tbl_v[u], exp_t);
        if (mode == 2) begin
            @(posedge clk); #1;
            start_v[u] = 1'b0;
            check({tag, "_rebusy"}, {31'd0, busy_v[u]}, 32'd1);
            check({tag, "_retclr"}, tbl_v[u], 32'd0);
            seen = 0;
            for (int c = 0; c < n + 4 && seen == 0; c++) begin
                @(posedge clk); #1;
                if (done_v[u]) seen = 1;
            end
            check({tag, "_redone"}, 32'(seen), 32'd1);
            check({tag, "_retable"}, tbl_v[u], exp_t);
            @(posedge clk); #1;
        end else begin
            seen = 0;
            for (int c = 0; c < 3; c++) begin
                @(posedge clk); #1;
                seen += int'(done_v[u]) + int'(busy_v[u]);
            end
            check({tag, "_quiet"}, 32'(seen), 32'd0);
        end
    endtask

    initial begin
        int          seen;
        int          u;
        logic [31:0] m;

        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            start_v[i] = 1'b0;
            mask_v[i]  = 32'd0;
        end
        #12;
        for (int i = 0; i < 2; i++) begin
            check("rst_busy",  {31'd0, busy_v[i]}, 32'd0);
            check("rst_done",  {31'd0, done_v[i]}, 32'd0);
            check("rst_vec",   vec(i), 32'd0);
            check("rst_table", tbl_v[i], 32'd0);
            check("rst_pass",  {31'd0, pass_v[i]}, 32'd0);
            check("rst_err",   {26'd0, err_v[i]}, 32'd0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_sweep("good_s1",  0, 1, 32'd0, 0);
        run_sweep("stuck0",   0, 1, golden_word(), 0);
        run_sweep("good_s3",  1, 3, 32'd0, 0);
        run_sweep("ignore",   0, 1, $urandom & $urandom, 1);
        run_sweep("heldstrt", 0, 1, $urandom & $urandom & $urandom, 2);
        run_sweep("inverted", 0, 1, 32'hFFFF_FFFF, 0);
        for (int k = 0; k < 4; k++) begin
            u = int'($urandom_range(0, 1));
            m = (k == 0) ? 32'h8000_0001 : ($urandom & $urandom);
            run_sweep("random", u, (u == 0) ? 1 : 3, m, int'($urandom_range(0, 1)));
        end

        // Asynchronous reset in the middle of a sweep, at vector 13.
        mask_v[0]  = 32'd0;
        start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        repeat (13) @(posedge clk);
        #1;
        check("mid_vec13", vec(0), 32'd13);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy",  {31'd0, busy_v[0]}, 32'd0);
        check("arst_done",  {31'd0, done_v[0]}, 32'd0);
        check("arst_vec",   vec(0), 32'd0);
        check("arst_table", tbl_v[0], 32'd0);
        check("arst_pass",  {31'd0, pass_v[0]}, 32'd0);
        check("arst_err",   {26'd0, err_v[0]}, 32'd0);
        #3 rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            seen += int'(done_v[0]) + int'(busy_v[0]);
        end
        check("post_rst_quiet", 32'(seen), 32'd0);
        run_sweep("after_rst", 0, 1, 32'd0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
